// File: rtl/game_ctl_if.sv
// Signal bundle between the game controller and the game core / video chain.
// The controller uses the slave view; the core side drives through the master view.
interface game_ctl_if;
    logic       start;
    logic       vsync;
    logic       colission;
    logic       captured;
    logic [4:0] points;
    logic       landed;
    logic [2:0] lvl;
    logic       landing_en;
    logic       game_rst;
    logic [2:0] state;
    logic [1:0] lives;
    logic [7:0] score;

    modport master (
        output start, vsync, colission, captured, points, landed,
        input  lvl, landing_en, game_rst, state, lives, score
    );

    modport slave (
        input  start, vsync, colission, captured, points, landed,
        output lvl, landing_en, game_rst, state, lives, score
    );
endinterface

// File: rtl/game_ctl.sv
// Game flow controller: tracks level, lives and score, sequences the
// play / crash / level-done / end screens on frame ticks.
module game_ctl #(
    parameter logic [2:0] MAX_LVL      = 3'd4,
    parameter logic [1:0] LIVES        = 2'd3,
    parameter logic [7:0] CRASH_FRAMES = 8'd60,
    parameter logic [7:0] LVL_FRAMES   = 8'd120
) (
    input logic       pclk,
    input logic       rst,
    game_ctl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAY      = 3'd1,
        S_CRASH     = 3'd2,
        S_LVL_DONE  = 3'd3,
        S_GAME_OVER = 3'd4,
        S_WIN       = 3'd5
    } state_e;

    localparam logic [2:0] LAST_LVL = MAX_LVL - 3'd1;

    state_e     state_q, state_d;
    logic [2:0] lvl_q, lvl_d;
    logic [1:0] lives_q, lives_d;
    logic [7:0] score_q, score_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       guard_q, guard_d;
    logic       landing_en_q, landing_en_d;
    logic       game_rst_q, game_rst_d;
    logic       start_q, vsync_q, captured_q;
    logic       armed_q;

    logic       start_edge_s;
    logic       frame_tick_s;
    logic       captured_edge_s;

    // armed_q blocks a start button that was already held when reset released
    assign start_edge_s    = bus.start & ~start_q & armed_q;
    assign frame_tick_s    = bus.vsync & ~vsync_q;
    assign captured_edge_s = bus.captured & ~captured_q;

    // State, counters, outputs and input edge history
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            lvl_q        <= 3'd0;
            lives_q      <= LIVES;
            score_q      <= 8'd0;
            frame_cnt_q  <= 8'd0;
            guard_q      <= 1'b0;
            landing_en_q <= 1'b0;
            game_rst_q   <= 1'b1;
            start_q      <= 1'b0;
            vsync_q      <= 1'b0;
            captured_q   <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lvl_q        <= lvl_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            frame_cnt_q  <= frame_cnt_d;
            guard_q      <= guard_d;
            landing_en_q <= landing_en_d;
            game_rst_q   <= game_rst_d;
            start_q      <= bus.start;
            vsync_q      <= bus.vsync;
            captured_q   <= bus.captured;
            armed_q      <= armed_q | ~bus.start;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        lvl_d       = lvl_q;
        lives_d     = lives_q;
        score_d     = score_q;
        frame_cnt_d = frame_cnt_q;
        guard_d     = guard_q;

        if ((state_q == S_PLAY) && captured_edge_s && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
        end else begin
            score_d = score_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_edge_s) begin
                    state_d = S_PLAY;
                    lvl_d   = 3'd0;
                    lives_d = LIVES;
                    score_d = 8'd0;
                    guard_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                // collision is checked first so it wins over a simultaneous landing
                if (guard_q && bus.colission) begin
                    state_d     = S_CRASH;
                    lives_d     = (lives_q != 2'd0) ? (lives_q - 2'd1) : 2'd0;
                    frame_cnt_d = 8'd0;
                end else if (guard_q && bus.landed && landing_en_q) begin
                    state_d     = S_LVL_DONE;
                    frame_cnt_d = 8'd0;
                end else if (frame_tick_s) begin
                    guard_d = 1'b1;
                end else begin
                    guard_d = guard_q;
                end
            end
            S_CRASH: begin
                if (frame_cnt_q == CRASH_FRAMES) begin
                    if (lives_q == 2'd0) begin
                        state_d = S_GAME_OVER;
                    end else begin
                        state_d = S_PLAY;
                        guard_d = 1'b0;
                    end
                end else if (frame_tick_s) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end
            end
            S_LVL_DONE: begin
                if (frame_cnt_q == LVL_FRAMES) begin
                    if (lvl_q == LAST_LVL) begin
                        state_d = S_WIN;
                    end else begin
                        state_d = S_PLAY;
                        lvl_d   = lvl_q + 3'd1;
                        guard_d = 1'b0;
                    end
                end else if (frame_tick_s) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end
            end
            S_GAME_OVER, S_WIN: begin
                if (start_edge_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        landing_en_d = (state_d == S_PLAY) && (bus.points == 5'b11111);
        game_rst_d   = (state_d != S_PLAY);
    end

    assign bus.state      = state_q;
    assign bus.lvl        = lvl_q;
    assign bus.lives      = lives_q;
    assign bus.score      = score_q;
    assign bus.landing_en = landing_en_q;
    assign bus.game_rst   = game_rst_q;

endmodule

// File: doc/game_ctl.md
GAME_CTL -- requirements
Module: game_ctl

Interface
REQ-001 Parameter MAX_LVL, default 3'd4: number of levels; the game is won after level MAX_LVL-1 is completed.
REQ-002 Parameter LIVES, default 2'd3: lives granted at game start.
REQ-003 Parameter CRASH_FRAMES, default 8'd60: frames spent in CRASH.
REQ-004 Parameter LVL_FRAMES, default 8'd120: frames spent in LEVEL_DONE.
REQ-005 pclk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  start button, already synchronised to pclk; level signal.
REQ-008 vsync  in  1  frame marker from the video chain; frame tick = rising edge.
REQ-009 colission  in  1  OR of all collision flags from the game core.
REQ-010 captured  in  1  point-capture flag from the game core; a rising edge means one point.
REQ-011 points  in  5  per-point captured mask from the game core.
REQ-012 landed  in  1  lander resting on a pad.
REQ-013 lvl  out  3  current level index to the game core.
REQ-014 landing_en  out  1  enables the goal landing pad.
REQ-015 game_rst  out  1  active-high synchronous reset to the game core.
REQ-016 state  out  3  FSM state code (see REQ-019).
REQ-017 lives  out  2  remaining lives.
REQ-018 score  out  8  captured-point counter.

Function
REQ-019 FSM states SHALL be: IDLE=0, PLAY=1, CRASH=2, LEVEL_DONE=3, GAME_OVER=4, WIN=5; codes 6-7 SHALL return to IDLE on the next edge.
REQ-020 All outputs SHALL be registered; a transition SHALL take effect one pclk after its triggering condition is sampled.
REQ-021 start_edge SHALL be start high while start was low on the previous cycle; frame_tick SHALL be the same edge detection applied to vsync.
REQ-022 IDLE: on start_edge -> PLAY, with lvl=0, lives=LIVES, score=0.
REQ-023 PLAY: a guard flag SHALL clear on entry; colission and landed SHALL be ignored until the first frame_tick in PLAY sets it.
REQ-024 PLAY, guard set, colission=1 -> CRASH and lives decrements by 1; lives SHALL never wrap below 0.
REQ-025 PLAY, guard set, landed=1 and landing_en=1, colission=0 -> LEVEL_DONE.
REQ-026 Priority: colission SHALL win over landed in the same cycle.
REQ-027 landed while landing_en=0 SHALL be ignored.
REQ-028 landing_en SHALL be 1 only in PLAY with points==5'b11111; otherwise 0.
REQ-029 A frame counter SHALL clear on entry to CRASH or LEVEL_DONE and increment on each frame_tick.
REQ-030 CRASH: when the count reaches CRASH_FRAMES -> GAME_OVER if lives==0, else PLAY at the same lvl.
REQ-031 LEVEL_DONE: when the count reaches LVL_FRAMES -> WIN if lvl==MAX_LVL-1, else PLAY with lvl incremented by 1.
REQ-032 GAME_OVER and WIN: on start_edge -> IDLE; lvl, lives and score SHALL hold their values for display.
REQ-033 game_rst SHALL be 1 in every state except PLAY.
REQ-034 score SHALL increment on each captured rising edge only while in PLAY, and SHALL saturate at 255.
REQ-035 start_edge in PLAY, CRASH or LEVEL_DONE SHALL be ignored.

Reset
REQ-036 rst=0 SHALL, immediately and asynchronously, force: state=IDLE, lvl=0, lives=LIVES, score=0, landing_en=0, game_rst=1, frame counter=0, guard=0, edge-detect history=0.
REQ-037 Assertion mid-game SHALL return to IDLE with no residual level or score.
REQ-038 After release, the first transition SHALL require a fresh start_edge, so start held high through reset SHALL NOT start a game.

Verification
REQ-039 Start: reset, pulse start -> one cycle later state=1, game_rst=0, lvl=0, lives=3, score=0.
REQ-040 Guard: colission=1 before the first vsync edge in PLAY -> no transition; after the vsync edge, colission=1 -> state=2, lives=2, game_rst=1; 60 frame ticks later -> state=1, lvl unchanged.
REQ-041 Game over: three post-guard crashes -> lives=0; 60 frames after the third crash -> state=4; start pulse -> state=0.
REQ-042 Level advance: points=11111 -> landing_en=1; landed=1 -> state=3; 120 frames later -> lvl=1, state=1; landed with points=01111 -> no transition.
REQ-043 Win and priority: at lvl=3, landed and colission in the same cycle -> CRASH; then a clean landing plus 120 frames -> state=5; 300 captured edges -> score=255.
REQ-044 Async reset: rst low mid-LEVEL_DONE, between clock edges -> outputs reach reset values before the next pclk edge; start held high through release -> stays IDLE.
